counter_8bit: RTL and testbench



---
 rtl/counter_8bit.sv | 40 ++++
 tb/tb_counter_8bit.sv | 139 +++++++++++++
 2 files changed

// File: rtl/counter_8bit.sv
// Loadable up/down counter with synchronous clear, parallel load and count enable.
// Priority per edge: clear, then load, then count (direction from inc), else hold.
module counter_8bit #(
    parameter int WIDTH = 8
) (
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] data_in,
    input  logic             inc,
    input  logic             clear,
    input  logic             load,
    input  logic             countEN,
    input  logic             clk
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] out_next;

    always_comb begin
        out_next = out_reg;
        if (load) begin
            out_next = data_in;
        end else if (countEN) begin
            // Unsigned WIDTH-bit arithmetic wraps naturally in both directions.
            out_next = inc ? (out_reg + ONE) : (out_reg - ONE);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            out_reg <= '0;
        end else begin
            out_reg <= out_next;
        end
    end

    assign out = out_reg;

endmodule

// File: tb/tb_counter_8bit.sv
// Scoreboard bench for counter_8bit: directed vectors push hand-computed expectations,
// a monitor pops and compares one entry after every rising edge.
module tb_counter_8bit;

    logic       clk;
    logic       clear;
    logic       load;
    logic       countEN;
    logic       inc;
    logic [7:0] data_in;
    logic [7:0] out;

    int checks = 0;
    int errors = 0;
    int vec_num = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_exp;
    bit         last_valid = 1'b0;

    counter_8bit #(.WIDTH(8)) dut (
        .out    (out),
        .data_in(data_in),
        .inc    (inc),
        .clear  (clear),
        .load   (load),
        .countEN(countEN),
        .clk    (clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one vector at the falling edge; the value expected after the next rising edge is queued.
    task automatic step(input logic c, input logic l, input logic e, input logic u,
                        input logic [7:0] d, input logic [7:0] exp_val);
        @(negedge clk);
        clear   = c;
        load    = l;
        countEN = e;
        inc     = u;
        data_in = d;
        exp_q.push_back(exp_val);
        #1;
        // Inputs changed mid-cycle must not reach out before the edge.
        if (last_valid) begin
            checks++;
            if (out !== last_exp) begin
                errors++;
                $display("FAIL no_comb_path vec %0d: out=%0d required=%0d", vec_num, out, last_exp);
            end
        end
        last_exp   = exp_val;
        last_valid = 1'b1;
        vec_num++;
    endtask

    // Monitor: the register presents a new value after every rising edge.
    initial begin : monitor
        logic [7:0] exp_val;
        int idx;
        idx = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_val = exp_q.pop_front();
                checks++;
                if (out !== exp_val) begin
                    errors++;
                    $display("FAIL count txn %0d: out=%0d required=%0d", idx, out, exp_val);
                end else begin
                    $display("txn %0d: clear=%b load=%b en=%b inc=%b data_in=%0d out=%0d ok",
                             idx, clear, load, countEN, inc, data_in, out);
                end
                idx++;
            end
        end
    end

    initial begin : stimulus
        int budget;
        clear = 1'b0; load = 1'b0; countEN = 1'b0; inc = 1'b0; data_in = 8'h00;

        // clear dominates load and count, and holds 0
        step(1, 1, 1, 1, 8'h55, 8'd0);
        step(1, 1, 1, 1, 8'h55, 8'd0);
        // load, held with countEN=1
        step(0, 1, 1, 0, 8'd4, 8'd4);
        step(0, 1, 1, 1, 8'd4, 8'd4);
        // hold with countEN=0
        step(0, 0, 0, 0, 8'd9, 8'd4);
        step(0, 0, 0, 1, 8'd9, 8'd4);
        step(0, 0, 0, 0, 8'd9, 8'd4);
        // down count through zero
        step(0, 0, 1, 0, 8'd0, 8'd3);
        step(0, 0, 1, 0, 8'd0, 8'd2);
        step(0, 0, 1, 0, 8'd0, 8'd1);
        step(0, 0, 1, 0, 8'd0, 8'd0);
        step(0, 0, 1, 0, 8'd0, 8'd255);
        step(0, 0, 1, 0, 8'd0, 8'd254);
        // up count through 255
        step(0, 1, 0, 0, 8'd253, 8'd253);
        step(0, 0, 1, 1, 8'd0, 8'd254);
        step(0, 0, 1, 1, 8'd0, 8'd255);
        step(0, 0, 1, 1, 8'd0, 8'd0);
        step(0, 0, 1, 1, 8'd0, 8'd1);
        // load beats simultaneous count, then counting resumes from loaded value
        step(0, 1, 1, 1, 8'd10, 8'd10);
        step(0, 0, 1, 1, 8'd10, 8'd11);
        // clear with load
        step(1, 1, 0, 0, 8'd99, 8'd0);
        // clear mid-count at 7, then resume from 0
        step(0, 1, 0, 0, 8'd5, 8'd5);
        step(0, 0, 1, 1, 8'd0, 8'd6);
        step(0, 0, 1, 1, 8'd0, 8'd7);
        step(1, 0, 1, 1, 8'd0, 8'd0);
        step(0, 0, 1, 1, 8'd0, 8'd1);
        // clear held, then first edge after release counts down
        step(1, 0, 0, 0, 8'd0, 8'd0);
        step(1, 0, 1, 0, 8'd0, 8'd0);
        step(0, 0, 1, 0, 8'd0, 8'd255);
        step(0, 0, 0, 0, 8'd0, 8'd255);

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
